// File: rtl/sipo_deserializer_32_bit_pkg.sv
// Shared constants and types for the 32-bit SIPO deserializer.
package sipo_pkg;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/sipo_deserializer_32_bit_if.sv
// Serial-in / parallel-out bus; the bench drives master, the deserializer is slave.
interface sipo_deserializer_32_bit_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

  logic                  Enable_In;
  logic                  Frame_Start_In;
  logic                  Serial_Valid_In;
  logic                  Serial_Data_In;
  logic                  Parallel_Ready_In;
  logic                  Overrun_Clear_In;
  logic [DATA_WIDTH-1:0] Parallel_Data_Out;
  logic                  Parallel_Valid_Out;
  logic                  Overrun_Out;
  logic [CNT_WIDTH-1:0]  Bit_Count_Out;

  modport master (
    output Enable_In, Frame_Start_In, Serial_Valid_In, Serial_Data_In,
           Parallel_Ready_In, Overrun_Clear_In,
    input  Parallel_Data_Out, Parallel_Valid_Out, Overrun_Out, Bit_Count_Out
  );

  modport slave (
    input  Enable_In, Frame_Start_In, Serial_Valid_In, Serial_Data_In,
           Parallel_Ready_In, Overrun_Clear_In,
    output Parallel_Data_Out, Parallel_Valid_Out, Overrun_Out, Bit_Count_Out
  );
endinterface

// File: rtl/sipo_deserializer_32_bit_output_stage.sv
// Valid/ready holding register for completed words with sticky overrun flag.
module sipo_output_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_ready,
  input  logic                  i_ovr_clear,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_overrun
);
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  w_drop;

  // A word arriving while the previous one is still unaccepted is dropped.
  assign w_drop = i_load && r_valid && !i_ready;

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_load && !w_drop) begin
        r_data  <= i_load_data;
        r_valid <= 1'b1;
      end else if (!i_load && i_ready) begin
        r_valid <= 1'b0;
      end

      if (w_drop)
        r_overrun <= 1'b1;
      else if (i_ovr_clear)
        r_overrun <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;
endmodule

// File: rtl/sipo_deserializer_32_bit.sv
// Serial-to-parallel receiver: bit counter with framing, feeding a valid/ready output stage.
//   state   | meaning
//   S_IDLE  | counter 0, no partial bits held
//   S_SHIFT | 1..DATA_WIDTH-1 bits of the current word held
module sipo_deserializer_32_bit
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit MSB_FIRST  = 1'b1,
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                       Clk_In,
  input  logic                       Reset_In,
  sipo_deserializer_32_bit_if.slave  bus
);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt, w_cnt_base;
  logic [DATA_WIDTH-1:0] r_sr, w_sr_nxt, w_sr_base, w_shifted;
  logic                  w_accept;
  logic                  w_load;

  assign w_accept = bus.Enable_In && bus.Serial_Valid_In;

  // Frame start realigns before the same-cycle bit, so that bit becomes bit 1.
  assign w_cnt_base = bus.Frame_Start_In ? '0 : r_cnt;
  assign w_sr_base  = bus.Frame_Start_In ? '0 : r_sr;
  assign w_shifted  = MSB_FIRST ? {w_sr_base[DATA_WIDTH-2:0], bus.Serial_Data_In}
                                : {bus.Serial_Data_In, w_sr_base[DATA_WIDTH-1:1]};

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    if (bus.Frame_Start_In) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_sr_nxt    = '0;
    end
    if (w_accept) begin
      w_sr_nxt = w_shifted;
      if (w_cnt_base == LAST_CNT) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = S_SHIFT;
        w_cnt_nxt   = w_cnt_base + 1'b1;
      end
    end
  end

  always_comb begin
    w_load = w_accept && (w_cnt_base == LAST_CNT);
  end

  sipo_output_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_output_stage (
    .Clk_In      (Clk_In),
    .Reset_In    (Reset_In),
    .i_load      (w_load),
    .i_load_data (w_shifted),
    .i_ready     (bus.Parallel_Ready_In),
    .i_ovr_clear (bus.Overrun_Clear_In),
    .o_data      (bus.Parallel_Data_Out),
    .o_valid     (bus.Parallel_Valid_Out),
    .o_overrun   (bus.Overrun_Out)
  );

  assign bus.Bit_Count_Out = r_cnt;
endmodule

// File: doc/sipo_deserializer_32_bit.md
Name: sipo_deserializer_32_bit

Overview:
Serial-In-Parallel-Out receiver that reassembles the MSB-first bit stream produced by the team's 32-bit PISO shift register into parallel words. It uses a bit counter and framing control, and delivers each completed word through a valid/ready output register. It sits at the receive end of the same serial link, feeding a downstream parallel consumer. It also flags overrun when the consumer stalls.

Parameters:
DATA_WIDTH, 32, word length in bits (>= 2)
MSB_FIRST, 1, 1 = first received bit lands in bit DATA_WIDTH-1 (matches PISO); 0 = first bit lands in bit 0
CNT_WIDTH, $clog2(DATA_WIDTH), width of bit counter (derived; do not override)

Ports:
Clk_In  input  1  clock, all state updates on rising edge
Reset_In  input  1  asynchronous, active-low reset
Enable_In  input  1  1 = shift path active; 0 = freeze shift register and counter
Frame_Start_In  input  1  discard partial word and realign counter to 0
Serial_Valid_In  input  1  Serial_Data_In is a valid bit this cycle
Serial_Data_In  input  1  serial data bit
Parallel_Ready_In  input  1  downstream accepts word when high with Parallel_Valid_Out
Overrun_Clear_In  input  1  clears sticky Overrun_Out
Parallel_Data_Out  output  DATA_WIDTH  completed word (registered)
Parallel_Valid_Out  output  1  word available
Overrun_Out  output  1  sticky: a completed word was dropped
Bit_Count_Out  output  CNT_WIDTH  bits received in current partial word

Behaviour:
- Reset (Reset_In low, async): shift register = 0, counter = 0, state = S_IDLE, Parallel_Data_Out = 0, Parallel_Valid_Out = 0, Overrun_Out = 0, Bit_Count_Out = 0.
- Bit accepted on an edge iff Enable_In & Serial_Valid_In.
- MSB_FIRST=1 shift: sr <= {sr[W-2:0], Serial_Data_In}. MSB_FIRST=0 shift: sr <= {Serial_Data_In, sr[W-1:1]}.
- States: S_IDLE (counter 0, no partial bits); S_SHIFT (1..W-1 bits held).
- IDLE->SHIFT on an accepted bit. SHIFT->IDLE on the accepted bit that makes count W-1 -> W (counter wraps to 0), or on Frame_Start_In.
- Word completion: the edge accepting bit W loads the holding register with the shifted value. Parallel_Valid_Out rises on that same edge, so latency is 0 cycles after the last bit edge.
- A back-to-back stream (bit every cycle) produces one word per W cycles with no gap.
- Holding register: Parallel_Valid_Out stays high and data stays stable until the edge where Parallel_Ready_In=1. Valid then clears unless a new word completes on that same edge.
- Completion on an edge with Valid=1 and Ready=1: the new word is loaded, Valid stays 1, no overrun.
- Completion on an edge with Valid=1 and Ready=0: the new word is dropped, the held word is kept, and Overrun_Out is set (sticky).
- Overrun_Out clears on an Overrun_Clear_In edge. If a set and a clear coincide, set wins.
- Frame_Start_In: counter <= 0 and the shift register is cleared. If an accepted bit arrives in the same cycle, that bit becomes bit 1 of the new word (counter = 1, state S_SHIFT). Frame_Start_In does not affect the holding register or Overrun_Out. It acts regardless of Enable_In.
- Enable_In=0: shift register, counter and state hold. The holding-register handshake and overrun clear still operate.
- Reset asserted mid-word: the partial word is lost. After release, the first accepted bit starts a fresh word.
- Bit_Count_Out = counter, registered. It reads 0 in S_IDLE and immediately after completion.

Decomposition:
- Package sipo_pkg: DATA_WIDTH default constant; state enum typedef {S_IDLE, S_SHIFT}.
- Sub-module sipo_output_stage: DATA_WIDTH holding register with valid/ready and overrun detection. The top level instantiates it with a one-cycle load strobe.

Test Plan:
- Reset, then 32 consecutive valid bits of 0xA5A55A5A MSB first -> Parallel_Data_Out=0xA5A55A5A with Valid=1 right after the 32nd bit edge; Bit_Count_Out=0.
- Loopback: PISO loaded with 0x12345678 and shifted, Serial_Data_Out wired to Serial_Data_In -> 0x12345678 received.
- 10 random bits, then Frame_Start_In, then 32 bits of 0xDEADBEEF -> output 0xDEADBEEF, no spurious word.
- Ready=0, two words 0x00000001 then 0xFFFFFFFF -> output holds 0x00000001, Overrun_Out=1. After Overrun_Clear_In -> Overrun_Out=0.
- Ready=1 on the same edge as the second word's completion -> 0xFFFFFFFF loaded, Valid stays 1, Overrun_Out=0.
- Enable_In toggled low for 5 cycles mid-word, and Reset_In pulsed low at bit 20 of a word -> counter frozen during disable. After reset, all outputs are 0 and the next 32 bits 0xCAFEF00D are received correctly.
